// File: rtl/detector_jogada_pkg.sv
// Shared state encodings and defaults for the button-press detector.
package pkg_detector_jogada;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    FILTRA   = 2'd1,
    REGISTRA = 2'd2,
    SOLTA    = 2'd3
  } estado_t;

  localparam int DEBOUNCE_CYCLES_PADRAO = 5;
  localparam int LARGURA_PADRAO         = 4;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on reset.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] i_d,
  output logic [LARGURA-1:0] o_q
);

  logic [LARGURA-1:0] r_s1;
  logic [LARGURA-1:0] r_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/detector_jogada.sv
// Synchronises and debounces the raw buttons, emitting one validated one-hot
// play per press (or an invalid-play pulse) and requiring a debounced release.
module detector_jogada
  import pkg_detector_jogada::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
  parameter int LARGURA         = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] botoes,
  input  logic               habilita,
  output logic [LARGURA-1:0] jogada,
  output logic               tem_jogada,
  output logic               jogada_invalida,
  output logic [1:0]         db_estado
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [LARGURA-1:0] w_s2;
  estado_t            r_estado;
  estado_t            w_estado_prox;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_prox;
  logic [LARGURA-1:0] r_cap;
  logic [LARGURA-1:0] w_cap_prox;
  logic [LARGURA-1:0] r_jogada;
  logic               r_tem;
  logic               r_inv;
  logic               w_um_quente;
  logic               w_tem_prox;
  logic               w_inv_prox;

  sincronizador_2ff #(.LARGURA(LARGURA)) u_sinc (
    .clock (clock),
    .reset (reset),
    .i_d   (botoes),
    .o_q   (w_s2)
  );

  assign w_um_quente = (r_cap != '0) && ((r_cap & (r_cap - LARGURA'(1))) == '0);

  // The counter never passes CNT_MAX: reaching it always leaves the state.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_cap_prox    = r_cap;
    case (r_estado)
      ESPERA: begin
        if (w_s2 != '0) begin
          w_cnt_prox = '0;
          if (habilita) begin
            w_cap_prox    = w_s2;
            w_estado_prox = FILTRA;
          end else begin
            w_estado_prox = SOLTA;
          end
        end
      end
      FILTRA: begin
        if (w_s2 == '0) begin
          w_estado_prox = ESPERA;
          w_cnt_prox    = '0;
        end else if (!habilita) begin
          w_estado_prox = SOLTA;
          w_cnt_prox    = '0;
        end else if (w_s2 != r_cap) begin
          w_cap_prox = w_s2;
          w_cnt_prox = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_estado_prox = REGISTRA;
        end else begin
          w_cnt_prox = r_cnt + CW'(1);
        end
      end
      REGISTRA: begin
        w_estado_prox = SOLTA;
        w_cnt_prox    = '0;
      end
      SOLTA: begin
        if (w_s2 != '0) begin
          w_cnt_prox = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_estado_prox = ESPERA;
          w_cnt_prox    = '0;
        end else begin
          w_cnt_prox = r_cnt + CW'(1);
        end
      end
      default: begin
        w_estado_prox = ESPERA;
        w_cnt_prox    = '0;
      end
    endcase
    w_tem_prox = (w_estado_prox == REGISTRA) && w_um_quente;
    w_inv_prox = (w_estado_prox == REGISTRA) && !w_um_quente;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= ESPERA;
      r_cnt    <= '0;
      r_cap    <= '0;
      r_jogada <= '0;
      r_tem    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
      r_cap    <= w_cap_prox;
      r_tem    <= w_tem_prox;
      r_inv    <= w_inv_prox;
      if (w_tem_prox) r_jogada <= r_cap;
    end
  end

  assign jogada          = r_jogada;
  assign tem_jogada      = r_tem;
  assign jogada_invalida = r_inv;
  assign db_estado       = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: pulses are predicted with their arrival
// cycle into a queue and matched by an independent negedge monitor.
module tb_detector_jogada;

  localparam int D = 5;
  localparam int L = 4;
  localparam int W = 17;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         habilita = 1'b1;
  logic [L-1:0] botoes = '0;
  logic [L-1:0] jogada;
  logic         tem_jogada;
  logic         jogada_invalida;
  logic [1:0]   db_estado;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [L-1:0] model_jogada = '0;
  logic [L-1:0] model_prox[$];

  detector_jogada #(.DEBOUNCE_CYCLES(D), .LARGURA(L)) dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .habilita        (habilita),
    .jogada          (jogada),
    .tem_jogada      (tem_jogada),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // driver tasks (called at a negedge)
  task automatic hold(input logic [L-1:0] v, input int n);
    botoes = v;
    repeat (n) @(negedge clock);
  endtask

  // Pulse seen at the negedge D+3 edges after the drive: 2 sync + capture + D.
  task automatic expect_pulse(input logic inv, input logic [L-1:0] valor);
    exp_q.push_back({16'(cyc + D + 3), inv});
    if (!inv) model_prox.push_back(valor);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (reset) model_jogada = '0;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1:1]) < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse got=none expected=cycle %0d inv=%0b", int'(e[W-1:1]), e[0]);
      if (!e[0] && model_prox.size() > 0) void'(model_prox.pop_front());
    end
    if (tem_jogada || jogada_invalida) begin
      check("no_dual_pulse", 32'(tem_jogada && jogada_invalida), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got=tem %0b inv %0b expected=none (cycle %0d)",
                 tem_jogada, jogada_invalida, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e[W-1:1]));
        check("pulse_kind_inv", 32'(jogada_invalida), 32'(e[0]));
        if (!e[0] && model_prox.size() > 0) model_jogada = model_prox.pop_front();
      end
    end
    check("jogada_held", 32'(jogada), 32'(model_jogada));
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_jogada", 32'(jogada), 32'd0);
    check("rst_tem", 32'(tem_jogada), 32'd0);
    check("rst_inv", 32'(jogada_invalida), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    hold('0, 3);

    // 1: clean single press
    expect_pulse(1'b0, 4'b0001);
    hold(4'b0001, 10);
    hold('0, 10);
    check("t1_estado", 32'(db_estado), 32'd0);

    // 2: short glitch is discarded
    hold(4'b0010, 3);
    hold('0, 10);
    check("t2_estado", 32'(db_estado), 32'd0);
    check("t2_jogada", 32'(jogada), 32'b0001);

    // 3: multi-button press then valid press
    expect_pulse(1'b1, 4'b0000);
    hold(4'b0101, 10);
    hold('0, 10);
    expect_pulse(1'b0, 4'b0100);
    hold(4'b0100, 10);
    hold('0, 10);

    // 4: long hold, short release ignored, proper release re-arms
    expect_pulse(1'b0, 4'b0100);
    hold(4'b0100, 40);
    hold('0, 2);
    hold(4'b0100, 10);
    check("t4_estado_solta", 32'(db_estado), 32'd3);
    hold('0, 6);
    expect_pulse(1'b0, 4'b0100);
    hold(4'b0100, 10);
    hold('0, 10);

    // 5: press while disabled must be released before acceptance
    habilita = 1'b0;
    hold(4'b1000, 10);
    check("t5_estado_solta", 32'(db_estado), 32'd3);
    habilita = 1'b1;
    hold(4'b1000, 10);
    hold('0, 10);
    check("t5_estado_espera", 32'(db_estado), 32'd0);
    expect_pulse(1'b0, 4'b1000);
    hold(4'b1000, 10);
    hold('0, 10);
    check("t5_jogada", 32'(jogada), 32'b1000);

    // 6: reset while filtering, button held through deassert
    hold(4'b0010, 5);
    check("t6_estado_filtra", 32'(db_estado), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_jogada", 32'(jogada), 32'd0);
    check("t6_rst_tem", 32'(tem_jogada), 32'd0);
    check("t6_rst_estado", 32'(db_estado), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    expect_pulse(1'b0, 4'b0010);
    hold(4'b0010, 10);
    hold('0, 10);
    check("t6_jogada", 32'(jogada), 32'b0010);

    repeat (5) @(negedge clock);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL pending_pulse got=none expected=cycle %0d inv=%0b", int'(e[W-1:1]), e[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
Input-conditioning stage directly upstream of jogo_desafio_memoria. It takes the raw asynchronous botoes[3:0] inputs and synchronises them, then debounces them. Each accepted press becomes one validated one-hot jogada plus a single-cycle tem_jogada pulse. Multi-button presses are rejected with a jogada_invalida pulse, and a new press is accepted only after a debounced release.

Parameters:
DEBOUNCE_CYCLES, 5, consecutive stable synchronised samples required to accept a press or a release (legal range >= 1)
LARGURA, 4, number of buttons

Ports:
clock  input  1  system clock (1 kHz in system use)
reset  input  1  asynchronous, active-high reset
botoes  input  LARGURA  raw button levels, asynchronous to clock
habilita  input  1  high = presses may be accepted (driven by the game FSM while waiting for a play)
jogada  output  LARGURA  last accepted one-hot code; held until the next valid press or reset
tem_jogada  output  1  one-cycle pulse; jogada was updated this cycle
jogada_invalida  output  1  one-cycle pulse; a debounced press was not one-hot
db_estado  output  2  current FSM state code, for debug

Behaviour:
- Reset (async, immediate):
  - jogada=0, tem_jogada=0, jogada_invalida=0.
  - Synchroniser flops=0, counter=0, captured value=0.
  - State=ESPERA.
- Synchroniser: 2-FF chain; s2 is botoes delayed by 2 edges. The FSM uses only s2.
- States and codes:
  - ESPERA=0: if s2!=0 and habilita=1, capture s2, cnt=0, go to FILTRA. If s2!=0 and habilita=0, go to SOLTA.
  - FILTRA=1:
    - s2==0: go to ESPERA (glitch discarded).
    - habilita=0: go to SOLTA.
    - s2!=captured and nonzero: recapture, cnt=0.
    - s2==captured: cnt++. When cnt reaches DEBOUNCE_CYCLES-1 on an edge where s2==captured, go to REGISTRA.
  - REGISTRA=2: lasts exactly 1 cycle and always completes, regardless of habilita.
    - Captured value one-hot: jogada<=captured, tem_jogada=1.
    - Otherwise: jogada_invalida=1 and jogada unchanged.
    - Next state is SOLTA.
  - SOLTA=3: cnt resets whenever s2!=0 and increments while s2==0. After DEBOUNCE_CYCLES consecutive zero samples, go to ESPERA.
- Outputs are registered. tem_jogada and jogada_invalida are high only during the cycle the FSM is in REGISTRA, and never both at once.
- Latency: botoes stable at V before edge k gives tem_jogada high in the cycle after edge k+2+DEBOUNCE_CYCLES (7 edges with the default). A 10-cycle press is therefore always accepted.
- Exactly one pulse per press, however long the button is held.
- Counter width is clog2(DEBOUNCE_CYCLES+1); the counter saturates and never wraps.
- Reset mid-operation aborts with no pulse. A button held through reset deassert is treated as a fresh press and needs the full latency.

Decomposition:
- Shared package pkg_detector_jogada: 2-bit state encodings ESPERA/FILTRA/REGISTRA/SOLTA and the default DEBOUNCE_CYCLES.
- One sub-module, sincronizador_2ff: parameterised width, async active-high reset, reset value 0.
- One-hot check (x!=0 && (x&(x-1))==0) stays inline.

Test Plan:
1. Reset, then botoes=0001 held 10 cycles -> after 7 edges tem_jogada=1 for exactly 1 cycle; jogada=0001 and held; jogada_invalida stays 0.
2. botoes=0010 for 3 cycles, then 0000 -> no tem_jogada, no jogada_invalida; db_estado returns to 0; jogada stays 0001.
3. botoes=0101 held 10 cycles -> jogada_invalida one-cycle pulse; jogada stays 0001; a following valid 0100 press is accepted normally.
4. botoes=0100 held 40 cycles, released 2 cycles, pressed 10 cycles -> exactly one pulse (jogada=0100). Repeat with a 6-cycle release -> second pulse appears.
5. habilita=0, botoes=1000 held; habilita raised mid-hold -> no pulse until release (>=5 zero samples) and re-press, then jogada=1000.
6. reset pulsed while in FILTRA with botoes=0010 held -> outputs 0 immediately. After reset deasserts, the pulse arrives 7 edges later with jogada=0010.
